slave_burst: RTL

//  Next-generation serial bus slave with parametrised slave-ID width and burst transfers.

---
 rtl/slave_burst_pkg.sv | 36 +++
 rtl/slave_burst_if.sv | 27 ++
 rtl/slave_burst_shift_unit.sv | 52 +++++
 rtl/slave_burst.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_burst_pkg.sv
// Shared types and constants for the burst serial-bus slave.
// States follow the frame order: header, per-beat write/read path, cleanup.
package slave_burst_pkg;

  typedef enum logic [4:0] {
    StIdle,
    StHdrMode,
    StHdrSid,
    StHdrAddr,
    StHdrLen,
    StHdrAck,
    StWaitPeer,
    StWrWait,
    StWrRx,
    StWrStrb,
    StWrMem,
    StWrAck,
    StRdReq,
    StRdMem,
    StRdGrant,
    StRdTx,
    StCleanup
  } state_e;

  localparam int unsigned ACK_CYCLES = 2;

  // Sub-phases shared by the ack and transmit states.
  localparam logic [1:0] PH_START = 2'd0;
  localparam logic [1:0] PH_BODY  = 2'd1;
  localparam logic [1:0] PH_STOP  = 2'd2;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_burst_if.sv
// Memory/arbiter-side signal bundle of the burst slave.
interface slave_burst_if #(
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic                     rd_wrt;
  logic                     bus_util;
  logic                     module_dv;
  logic                     arbiter_cmd_in;
  logic [DATA_WIDTH-1:0]    data_in_parellel;
  logic                     write_en_internal;
  logic                     req_int_data;
  logic                     busy_out;
  logic [DATA_WIDTH-1:0]    data_out_parellel;
  logic [ADDRESS_WIDTH-1:0] addr_buff;
  logic                     timeout_err;

  modport slave (
    input  rd_wrt, bus_util, module_dv, arbiter_cmd_in, data_in_parellel,
    output write_en_internal, req_int_data, busy_out, data_out_parellel, addr_buff, timeout_err
  );

  modport master (
    output rd_wrt, bus_util, module_dv, arbiter_cmd_in, data_in_parellel,
    input  write_en_internal, req_int_data, busy_out, data_out_parellel, addr_buff, timeout_err
  );
endinterface

// File: rtl/slave_burst_shift_unit.sv
// Load/shift register with a run-time bit count, MSB first in both directions.
// 'shifted' is the post-shift value so the caller can capture a field on 'done'.
module slave_burst_shift_unit #(
  parameter int unsigned WIDTH = 15,
  localparam int unsigned LenW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [LenW-1:0]  len,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] shifted,
  output logic             sout,
  output logic             done
);

  logic [WIDTH-1:0] val_q, val_d;
  logic [LenW-1:0]  len_q, len_d, cnt_q, cnt_d;

  assign shifted = {val_q[WIDTH-2:0], sin};
  assign sout    = val_q[len_q - LenW'(1)];
  assign done    = shift && (cnt_q == LenW'(1));

  always_comb begin
    val_d = val_q;
    len_d = len_q;
    cnt_d = cnt_q;
    if (load) begin
      val_d = load_val;
      len_d = len;
      cnt_d = len;
    end else if (shift && (cnt_q != '0)) begin
      val_d = shifted;
      cnt_d = cnt_q - LenW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_burst.sv
// Serial-bus burst slave: decodes a header, then runs N+1 write or read beats
// against the memory side with address auto-increment and a stall timeout.
module slave_burst
  import slave_burst_pkg::*;
#(
  parameter int unsigned            ADDRESS_WIDTH  = 15,
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter int unsigned            SID_WIDTH      = 3,
  parameter logic [SID_WIDTH-1:0]   SELF_ID        = '0,
  parameter int unsigned            BURST_WIDTH    = 4,
  parameter int unsigned            TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          rstn,
  slave_burst_if.slave bus,
  inout wire           data_bus_serial
);

  localparam int unsigned MaxW = max_w(max_w(ADDRESS_WIDTH, DATA_WIDTH),
                                       max_w(SID_WIDTH, BURST_WIDTH));
  localparam int unsigned LenW = $clog2(MaxW + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  state_e                   state_q, state_d;
  logic [1:0]               phase_q, phase_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [BURST_WIDTH-1:0]   beat_q, beat_d, len_q, len_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     rw_q, rw_d;

  logic            sh_load, sh_shift, sh_sout, sh_done;
  logic [MaxW-1:0] sh_val, sh_shifted;
  logic [LenW-1:0] sh_len;
  logic            drv_en, drv_val, wr_en, rd_req, busy, timeout, timed, beat_end;
  logic            line_in;

  assign line_in         = data_bus_serial;
  assign data_bus_serial = drv_en ? drv_val : 1'bz;

  slave_burst_shift_unit #(.WIDTH(MaxW)) u_shift (
    .clk      (clk),
    .rstn     (rstn),
    .load     (sh_load),
    .load_val (sh_val),
    .len      (sh_len),
    .shift    (sh_shift),
    .sin      (line_in),
    .shifted  (sh_shifted),
    .sout     (sh_sout),
    .done     (sh_done)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    beat_d   = beat_q;
    len_d    = len_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    sh_load  = 1'b0;
    sh_val   = '0;
    sh_len   = '0;
    sh_shift = 1'b0;
    drv_en   = 1'b0;
    drv_val  = 1'b1;
    wr_en    = 1'b0;
    rd_req   = 1'b0;
    busy     = 1'b0;
    timed    = 1'b0;
    timeout  = 1'b0;
    beat_end = 1'b0;

    unique case (state_q)
      StIdle:     if (!line_in) state_d = StHdrMode;
      StHdrMode: begin
        if (!line_in) begin
          state_d = StHdrSid;
          sh_load = 1'b1;
          sh_len  = LenW'(SID_WIDTH);
        end else begin
          state_d = StWaitPeer;
        end
      end
      StHdrSid: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          if (sh_shifted[SID_WIDTH-1:0] == SELF_ID) begin
            state_d = StHdrAddr;
            sh_load = 1'b1;
            sh_len  = LenW'(ADDRESS_WIDTH);
          end else begin
            state_d = StWaitPeer;
          end
        end
      end
      StWaitPeer: if (!bus.bus_util) state_d = StIdle;
      StHdrAddr: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          addr_d  = sh_shifted[ADDRESS_WIDTH-1:0];
          state_d = StHdrLen;
          sh_load = 1'b1;
          sh_len  = LenW'(BURST_WIDTH);
        end
      end
      StHdrLen: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          len_d   = sh_shifted[BURST_WIDTH-1:0];
          beat_d  = '0;
          state_d = StHdrAck;
        end
      end
      StHdrAck: begin
        drv_en  = 1'b1;
        drv_val = 1'b0;
        if (phase_q == 2'(ACK_CYCLES - 1)) begin
          rw_d    = bus.rd_wrt;
          state_d = bus.rd_wrt ? StWrWait : StRdReq;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StWrWait: begin
        timed = 1'b1;
        if (!line_in) begin
          state_d = StWrRx;
          sh_load = 1'b1;
          sh_len  = LenW'(DATA_WIDTH);
        end
      end
      StWrRx: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          wdata_d = sh_shifted[DATA_WIDTH-1:0];
          state_d = StWrStrb;
        end
      end
      StWrStrb: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        state_d = StWrMem;
      end
      StWrMem: begin
        timed = 1'b1;
        busy  = 1'b1;
        if (bus.module_dv) state_d = StWrAck;
      end
      StWrAck: begin
        unique case (phase_q)
          PH_START: if (bus.arbiter_cmd_in) phase_d = PH_BODY;
          PH_BODY: begin
            drv_en  = 1'b1;
            drv_val = 1'b0;
            phase_d = PH_STOP;
          end
          default: begin
            drv_en   = 1'b1;
            beat_end = 1'b1;
          end
        endcase
      end
      StRdReq: begin
        rd_req  = 1'b1;
        busy    = 1'b1;
        state_d = StRdMem;
      end
      StRdMem: begin
        timed = 1'b1;
        busy  = 1'b1;
        // The shifter doubles as the read-data latch until transmit.
        if (bus.module_dv) begin
          sh_load = 1'b1;
          sh_val  = MaxW'(bus.data_in_parellel);
          sh_len  = LenW'(DATA_WIDTH);
          state_d = StRdGrant;
        end
      end
      StRdGrant: begin
        timed = 1'b1;
        if (bus.arbiter_cmd_in) state_d = StRdTx;
      end
      StRdTx: begin
        drv_en = 1'b1;
        unique case (phase_q)
          PH_START: begin
            drv_val = 1'b0;
            phase_d = PH_BODY;
          end
          PH_BODY: begin
            drv_val  = sh_sout;
            sh_shift = 1'b1;
            if (sh_done) phase_d = PH_STOP;
          end
          default: beat_end = 1'b1;
        endcase
      end
      StCleanup: begin
        state_d = StIdle;
        beat_d  = '0;
        len_d   = '0;
        addr_d  = '0;
        wdata_d = '0;
        rw_d    = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (beat_end) begin
      if (beat_q == len_q) begin
        state_d = StCleanup;
      end else begin
        beat_d  = beat_q + BURST_WIDTH'(1);
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        state_d = rw_q ? StWrWait : StRdReq;
      end
    end

    if (timed && (state_d == state_q) && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
      timeout = 1'b1;
      state_d = StIdle;
      beat_d  = '0;
      len_d   = '0;
      addr_d  = '0;
      wdata_d = '0;
      rw_d    = 1'b0;
    end

    if (state_d != state_q) phase_d = '0;
    timer_d = (timed && (state_d == state_q)) ? timer_q + TW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      phase_q <= '0;
      timer_q <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  end

  assign bus.write_en_internal = wr_en;
  assign bus.req_int_data      = rd_req;
  assign bus.busy_out          = busy;
  assign bus.data_out_parellel = wdata_q;
  assign bus.addr_buff         = addr_q;
  assign bus.timeout_err       = timeout;

endmodule
